// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with glitch rejection, sticky framing/overrun flags and a
// first-word-fall-through byte FIFO on the client side.
module uart_rx_buffered #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic             rx,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [7:0]       dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             rx_busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [TICK_W-1:0] HALF_M1 = TICK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] BIT_M1  = TICK_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync3;
  logic              w_rxs;
  logic              w_fall;

  logic [TICK_W-1:0] r_tick;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              w_tick_zero;

  logic              w_stop_ok;
  logic              w_set_fe;
  logic              w_push;
  logic              w_pop;
  logic              w_set_ov;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  w_next_rd;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [7:0]        w_head;
  logic [7:0]        r_dout;
  logic              r_frame_err;
  logic              r_overrun;
  logic              w_empty;
  logic              w_full;

  // Input synchronizer; third flop gives the previous rxs for edge detection
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_rxs       = r_sync2;
  assign w_fall      = r_sync3 & ~r_sync2;
  assign w_tick_zero = (r_tick == '0);

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stop_ok   = 1'b0;
    w_set_fe    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_tick_zero) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick_zero && (r_bit == 3'd7)) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick_zero) begin
          if (w_rxs) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_set_fe    = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing and shift register; IDLE keeps the half-bit preload ready
  always_ff @(posedge clk_50m) begin
    case (r_state)
      S_IDLE: begin
        r_tick <= HALF_M1;
        r_bit  <= 3'd0;
      end
      S_START, S_STOP: begin
        r_tick <= w_tick_zero ? BIT_M1 : r_tick - TICK_W'(1);
      end
      S_DATA: begin
        if (w_tick_zero) begin
          r_tick  <= BIT_M1;
          r_shift <= {w_rxs, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end else begin
          r_tick <= r_tick - TICK_W'(1);
        end
      end
      default: r_tick <= r_tick;
    endcase
  end

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop       = rd_en & ~w_empty;
  assign w_push      = w_stop_ok & (~w_full | w_pop);
  assign w_set_ov    = w_stop_ok & w_full & ~w_pop;
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_next_rd   = r_rd_ptr + PTR_W'(w_pop);

  // New head bypasses the memory when the incoming byte becomes the only entry
  assign w_head = (w_push && (w_next_rd == r_wr_ptr)) ? r_shift : r_mem[w_next_rd];

  always_ff @(posedge clk_50m) begin
    if (w_push) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= 8'h00;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_next_rd;
      r_count  <= w_count_nxt;
      if (w_count_nxt != '0) r_dout <= w_head;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_set_fe)     r_frame_err <= 1'b1;
      else if (err_clr) r_frame_err <= 1'b0;
      if (w_set_ov)     r_overrun   <= 1'b1;
      else if (err_clr) r_overrun   <= 1'b0;
    end
  end

  assign dout      = r_dout;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign rx_busy   = (r_state != S_IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: serial stimulus with a byte-level
// reference queue, popped and compared by an independent read monitor.
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx;
  logic             rd_en;
  logic             err_clr;
  logic [7:0]       dout;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             rx_busy;
  logic             frame_err;
  logic             overrun;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr;

  uart_rx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk_50m  (clk),
    .rst      (rst),
    .rx       (rx),
    .rd_en    (rd_en),
    .err_clr  (err_clr),
    .dout     (dout),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
    rx = 1'b1;
  endtask

  // Reference: a well-framed byte is kept if there is room, otherwise lost as overrun
  task automatic send_good(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovr = 1'b1;
    send_byte(b, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_en = 1'b1;
    while (!empty && n < 2 * DEPTH) begin
      tick(1);
      n++;
    end
    rd_en = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_queue_left", exp_q.size(), 0);
    check("drain_count", count, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_dout"}, dout, 8'h00);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_busy"}, rx_busy, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  // Read monitor: every accepted pop must match the next expected byte
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rd_en && !empty && !rst) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got %0h expected no byte", dout);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", dout, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [7:0] b;
    rst = 1'b1;
    rx = 1'b1;
    rd_en = 1'b0;
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    tick(4);

    // Single byte with latency measurement from the rx falling edge
    exp_q.push_back(8'h55);
    lat = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        while (empty && lat < 20 * CPB) begin
          tick(1);
          lat++;
        end
      end
    join
    check("t1_latency_in_window", (lat >= 150 && lat <= 162), 1);
    check("t1_count", count, 1);
    check("t1_dout_peek", dout, 8'h55);
    drain();

    // Back-to-back bytes, no gap
    exp_q.push_back(8'hA3);
    send_byte(8'hA3, 1'b1);
    exp_q.push_back(8'h00);
    send_byte(8'h00, 1'b1);
    exp_q.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    tick(4);
    check("t2_count", count, 3);
    check("t2_frame_err", frame_err, 0);
    check("t2_overrun", overrun, 0);
    drain();

    // Overfill: seventeenth byte is dropped
    exp_ovr = 1'b0;
    for (int i = 0; i < 17; i++) send_good(8'(i));
    tick(4);
    check("t3_full", full, 1);
    check("t3_count", count, DEPTH);
    check("t3_overrun", overrun, exp_ovr);
    check("t3_frame_err", frame_err, 0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t3_overrun_cleared", overrun, 0);
    check("t3_full_kept", full, 1);
    drain();

    // Framing error, then recovery
    send_byte(8'h3C, 1'b0);
    tick(2 * CPB);
    check("t4_frame_err", frame_err, 1);
    check("t4_count", count, 0);
    check("t4_busy_idle", rx_busy, 0);
    send_good(8'h7E);
    tick(4);
    check("t4_count_after", count, 1);
    check("t4_dout", dout, 8'h7E);
    drain();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t4_frame_err_cleared", frame_err, 0);

    // Short glitch is rejected
    rx = 1'b0;
    tick(4);
    check("t5_busy_during", rx_busy, 1);
    rx = 1'b1;
    tick(CPB);
    check("t5_busy_after", rx_busy, 0);
    check("t5_count", count, 0);
    check("t5_frame_err", frame_err, 0);
    check("t5_overrun", overrun, 0);

    // Reset in the middle of data bit 4 with one byte already buffered
    send_good(8'h42);
    tick(2);
    check("t6_pre_count", count, 1);
    b = 8'h5A;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[4];
    tick(CPB / 2);
    check("t6_busy_mid_frame", rx_busy, 1);
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    check_reset("t6_reset");
    rst = 1'b0;
    exp_q.delete();
    tick(2 * CPB);
    check("t6_no_partial", count, 0);
    send_good(8'h81);
    tick(4);
    check("t6_count", count, 1);
    check("t6_dout", dout, 8'h81);
    drain();

    // Random bursts that fit the FIFO
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        send_good(b);
      end
      tick(4);
      check("rand_count", count, n);
      check("rand_overrun", overrun, 0);
      check("rand_frame_err", frame_err, 0);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
